dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the load/store interface that the CPU memory stage drives.
- Accepts word-addressed read/write requests over a valid/ready handshake.
- Executes each request against an internal word array and returns one response per request, in order, after a fixed configurable latency.
- Supports backpressure on both request and response channels. It is the standalone memory model the pipelined core and its benches attach to.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_rsp_fifo.sv | 61 ++++++
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds the response record carried through the delay line and queue,
// the default geometry constants and a width helper for counters.
package dmem_pkg;

    localparam int DMEM_DATA_W     = 32;
    localparam int DMEM_ADDR_W     = 10;
    localparam int DMEM_LATENCY    = 2;
    localparam int DMEM_FIFO_DEPTH = 4;

    typedef struct packed {
        logic                   we;
        logic [DMEM_DATA_W-1:0] rdata;
    } dmem_rsp_t;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Purpose: in-order response queue of dmem_rsp_t records.
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: caller must not push when full; pop only takes effect when not empty.
module dmem_rsp_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  dmem_rsp_t push_dat,
    input  logic      pop,
    output dmem_rsp_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    dmem_rsp_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_pop;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap explicitly at DEPTH-1 and the occupancy count tracks push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: word-addressed data memory answering load/store requests in order.
// Latency: response valid exactly LATENCY cycles after accept when the queue is empty.
// Backpressure: req_ready_o drops once FIFO_DEPTH requests are outstanding; responses hold until taken.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int MEM_ADDR_W = DMEM_ADDR_W,
    parameter int LATENCY    = DMEM_LATENCY,
    parameter int FIFO_DEPTH = DMEM_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [MEM_ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_we_o,
    output logic [DATA_W-1:0]     rsp_rdata_o
);

    localparam int CNT_W = clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem [2**MEM_ADDR_W];
    logic [CNT_W-1:0]  outstanding;
    logic              accept;
    logic              pop;
    dmem_rsp_t         acc_rsp;
    dmem_rsp_t         fifo_in;
    dmem_rsp_t         fifo_head;
    logic              fifo_push_req;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;

    // Credit comes only from the registered count, so ready never sees rsp_ready_i.
    assign req_ready_o = (outstanding < CNT_W'(FIFO_DEPTH));
    assign accept      = req_valid_i && req_ready_o && !reset;
    assign pop         = rsp_valid_o && rsp_ready_i;

    // Reads sample the array before this edge's write; only one request per edge, so no hazard.
    assign acc_rsp.we    = req_we_i;
    assign acc_rsp.rdata = req_we_i ? '0 : DMEM_DATA_W'(mem[req_addr_i]);

    // Array write on the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && req_we_i) begin
            mem[req_addr_i] <= req_wdata_i;
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign fifo_push_req = accept;
            assign fifo_in       = acc_rsp;
        end else begin : g_pipe
            logic [LATENCY-2:0] stg_vld;
            dmem_rsp_t          stg_dat [LATENCY-1];

            // Valid bits of the delay line are cleared on reset to drop in-flight work.
            always_ff @(posedge clk) begin
                if (reset) begin
                    stg_vld <= '0;
                end else begin
                    stg_vld[0] <= accept;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        stg_vld[i] <= stg_vld[i-1];
                    end
                end
            end

            // Payload of the delay line shifts every cycle alongside its valid bit.
            always_ff @(posedge clk) begin
                stg_dat[0] <= acc_rsp;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    stg_dat[i] <= stg_dat[i-1];
                end
            end

            assign fifo_push_req = stg_vld[LATENCY-2];
            assign fifo_in       = stg_dat[LATENCY-2];
        end
    endgenerate

    // The credit counter guarantees space; the full check is a safety net only.
    assign fifo_push = fifo_push_req && !fifo_full;

    dmem_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (fifo_in),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rsp_valid_o = !fifo_empty;
    assign rsp_we_o    = rsp_valid_o && fifo_head.we;
    assign rsp_rdata_o = rsp_valid_o ? DATA_W'(fifo_head.rdata) : '0;

    // Outstanding count: delay line plus queue; simultaneous accept and pop cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 4; depth 4) each checked
// every cycle against a timestamped in-order queue model, plus directed literal checks.
module tb_dmem_responder;

    localparam int DEPTH = 4;

    typedef struct {
        bit          we;
        logic [31:0] d;
        int          avail;
    } exp_t;

    typedef struct {
        bit          we;
        logic [31:0] d;
        int          t;
    } obs_t;

    logic        clk;
    logic        reset;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [9:0]  req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic        rsp_we    [3];
    logic [31:0] rsp_rdata [3];

    int   cyc;
    int   n_chk;
    int   n_fail;
    bit   chk_en;
    obs_t log0 [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

        dmem_responder #(
            .DATA_W     (32),
            .MEM_ADDR_W (10),
            .LATENCY    (LAT),
            .FIFO_DEPTH (DEPTH)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_we_i    (req_we[g]),
            .req_addr_i  (req_addr[g]),
            .req_wdata_i (req_wdata[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready[g]),
            .rsp_we_o    (rsp_we[g]),
            .rsp_rdata_o (rsp_rdata[g])
        );

        exp_t        q [$];
        logic [31:0] mm [1024];
        exp_t        e;
        bit          acc;
        bit          pop;

        // Model: queue size is the outstanding count; an entry is presentable from accept+LAT.
        always @(posedge clk) begin
            if (reset) begin
                q.delete();
            end else begin
                pop = (q.size() > 0) && (q[0].avail <= cyc) && rsp_ready[g];
                acc = req_valid[g] && (q.size() < DEPTH);
                if (acc) begin
                    e.we    = req_we[g];
                    e.d     = req_we[g] ? 32'h0 : mm[req_addr[g]];
                    e.avail = cyc + LAT;
                    if (req_we[g]) mm[req_addr[g]] = req_wdata[g];
                    q.push_back(e);
                end
                if (pop) q.pop_front();
            end
        end

        // Per-cycle comparison against the model, away from the active edge.
        always @(negedge clk) begin
            if (chk_en) begin
                bit exp_v;
                exp_v = (q.size() > 0) && (q[0].avail <= cyc);
                chk($sformatf("d%0d_req_ready", g), {31'h0, req_ready[g]}, {31'h0, q.size() < DEPTH});
                chk($sformatf("d%0d_rsp_valid", g), {31'h0, rsp_valid[g]}, {31'h0, exp_v});
                chk($sformatf("d%0d_rsp_we", g), {31'h0, rsp_we[g]}, {31'h0, exp_v ? q[0].we : 1'b0});
                chk($sformatf("d%0d_rsp_rdata", g), rsp_rdata[g], exp_v ? q[0].d : 32'h0);
                if (g == 0 && rsp_valid[g] === 1'b1 && rsp_ready[g] === 1'b1) begin
                    log0.push_back('{we: rsp_we[g], d: rsp_rdata[g], t: cyc});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input bit we, input logic [9:0] a, input logic [31:0] d,
                         output int tacc);
        int n;
        n = 0;
        step();
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = a;
        req_wdata[k] = d;
        while (req_ready[k] !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: dut %0d never ready, expected ready within 200 cycles", k);
        end
        tacc = cyc;
    endtask

    task automatic idle(input int k);
        step();
        req_valid[k] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, tl, acc_cnt, lat;
        cyc    = 0;
        n_chk  = 0;
        n_fail = 0;
        chk_en = 1'b0;
        reset  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            rsp_ready[k] = 1'b1;
        end
        step();
        chk_en = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("reset_req_ready", {31'h0, req_ready[0]}, 32'h1);
        chk("reset_rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
        chk("reset_rsp_we", {31'h0, rsp_we[0]}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata[0], 32'h0);

        // Write then read the same word.
        issue(0, 1'b1, 10'h005, 32'hDEADBEEF, t0);
        issue(0, 1'b0, 10'h005, 32'h0, t1);
        idle(0);
        while (cyc < t0 + 2) step();
        chk("wr_ack_valid", {31'h0, rsp_valid[0]}, 32'h1);
        chk("wr_ack_we", {31'h0, rsp_we[0]}, 32'h1);
        chk("wr_ack_rdata", rsp_rdata[0], 32'h0);
        step();
        chk("rd_valid", {31'h0, rsp_valid[0]}, 32'h1);
        chk("rd_we", {31'h0, rsp_we[0]}, 32'h0);
        chk("rd_rdata", rsp_rdata[0], 32'hDEADBEEF);

        // Streaming: preload addr*3, then 16 back-to-back reads.
        for (int i = 0; i < 16; i++) issue(0, 1'b1, 10'(i), 32'(i * 3), t1);
        idle(0);
        repeat (6) step();
        log0.delete();
        issue(0, 1'b0, 10'h000, 32'h0, t0);
        for (int i = 1; i < 16; i++) issue(0, 1'b0, 10'(i), 32'h0, tl);
        idle(0);
        repeat (6) step();
        chk("stream_no_stall", 32'(tl - t0), 32'd15);
        chk("stream_count", 32'(log0.size()), 32'd16);
        for (int i = 0; i < 16 && i < log0.size(); i++) begin
            chk($sformatf("stream_data_%0d", i), log0[i].d, 32'(i * 3));
            chk($sformatf("stream_cycle_%0d", i), 32'(log0[i].t), 32'(t0 + 2 + i));
        end

        // Backpressure until full, then release one response.
        log0.delete();
        step();
        rsp_ready[0] = 1'b0;
        acc_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            req_valid[0] = 1'b1;
            req_we[0]    = 1'b0;
            req_addr[0]  = 10'(acc_cnt);
            if (req_ready[0] === 1'b1) acc_cnt++;
        end
        chk("full_accepted", 32'(acc_cnt), 32'd4);
        chk("full_ready_low", {31'h0, req_ready[0]}, 32'h0);
        chk("full_head_valid", {31'h0, rsp_valid[0]}, 32'h1);
        chk("full_head_data", rsp_rdata[0], 32'h0);
        step();
        rsp_ready[0] = 1'b1;
        chk("full_still_low", {31'h0, req_ready[0]}, 32'h0);
        step();
        rsp_ready[0] = 1'b0;
        chk("credit_back", {31'h0, req_ready[0]}, 32'h1);
        chk("next_head_data", rsp_rdata[0], 32'h3);
        step();
        chk("refull_ready_low", {31'h0, req_ready[0]}, 32'h0);
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        repeat (10) step();
        chk("bp_rsp_count", 32'(log0.size()), 32'd5);
        if (log0.size() == 5) chk("bp_last_data", log0[4].d, 32'd12);

        // Simultaneous accept and pop with three outstanding.
        step();
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 10'd6, 32'h0, t1);
        issue(0, 1'b0, 10'd7, 32'h0, t1);
        issue(0, 1'b0, 10'd8, 32'h0, t1);
        idle(0);
        step();
        step();
        chk("three_ready", {31'h0, req_ready[0]}, 32'h1);
        chk("three_head", rsp_rdata[0], 32'd18);
        req_valid[0] = 1'b1;
        req_addr[0]  = 10'd9;
        rsp_ready[0] = 1'b1;
        step();
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b0;
        chk("simul_ready", {31'h0, req_ready[0]}, 32'h1);
        chk("simul_head", rsp_rdata[0], 32'd21);
        step();
        req_valid[0] = 1'b1;
        req_addr[0]  = 10'd10;
        step();
        req_valid[0] = 1'b0;
        chk("simul_then_full", {31'h0, req_ready[0]}, 32'h0);
        rsp_ready[0] = 1'b1;
        repeat (10) step();

        // Reset with reads in flight; array contents must survive.
        issue(0, 1'b1, 10'h3FF, 32'h12345678, t1);
        idle(0);
        repeat (4) step();
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 10'd1, 32'h0, t1);
        issue(0, 1'b0, 10'd2, 32'h0, t1);
        issue(0, 1'b0, 10'd3, 32'h0, t1);
        idle(0);
        step();
        step();
        reset = 1'b1;
        log0.delete();
        step();
        reset = 1'b0;
        chk("post_reset_valid", {31'h0, rsp_valid[0]}, 32'h0);
        chk("post_reset_ready", {31'h0, req_ready[0]}, 32'h1);
        rsp_ready[0] = 1'b1;
        repeat (8) step();
        chk("no_stale_rsp", 32'(log0.size()), 32'd0);
        issue(0, 1'b0, 10'h3FF, 32'h0, t1);
        idle(0);
        repeat (6) step();
        chk("survive_count", 32'(log0.size()), 32'd1);
        if (log0.size() == 1) chk("survive_data", log0[0].d, 32'h12345678);

        // Latency sweep on the LATENCY=1 and LATENCY=4 instances.
        for (int k = 1; k < 3; k++) begin
            lat = (k == 1) ? 1 : 4;
            issue(k, 1'b1, 10'h020, 32'hA5A50000 + 32'(k), t0);
            for (int c = 0; c < lat; c++) begin
                chk($sformatf("lat%0d_wr_early", lat), {31'h0, rsp_valid[k]}, 32'h0);
                step();
                req_valid[k] = 1'b0;
            end
            chk($sformatf("lat%0d_wr_valid", lat), {31'h0, rsp_valid[k]}, 32'h1);
            chk($sformatf("lat%0d_wr_we", lat), {31'h0, rsp_we[k]}, 32'h1);
            chk($sformatf("lat%0d_wr_cycle", lat), 32'(cyc - t0), 32'(lat));
            issue(k, 1'b0, 10'h020, 32'h0, t0);
            for (int c = 0; c < lat; c++) begin
                step();
                req_valid[k] = 1'b0;
            end
            chk($sformatf("lat%0d_rd_valid", lat), {31'h0, rsp_valid[k]}, 32'h1);
            chk($sformatf("lat%0d_rd_data", lat), rsp_rdata[k], 32'hA5A50000 + 32'(k));
            for (int i = 0; i < 6; i++) issue(k, 1'b0, 10'h020, 32'h0, t1);
            idle(k);
            repeat (10) step();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
